// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a value source and the sequential BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  signed_mode;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  negative;

    modport master (
        output start, signed_mode, value,
        input  busy, done, bcd, negative
    );

    modport slave (
        input  start, signed_mode, value,
        output busy, done, bcd, negative
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Signed-magnitude binary to BCD converter, shift-and-add-3, one bit per cycle.
// Latency: done/bcd appear WIDTH edges after the accepting start edge.
// Backpressure: start is ignored while busy; no queueing of requests.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * DIGITS;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic            neg_q, neg_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            negative_q, negative_d;
    logic            done_q, done_d;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   shifted;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            scratch_q  <= '0;
            mag_q      <= '0;
            neg_q      <= 1'b0;
            bcd_q      <= '0;
            negative_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scratch_q  <= scratch_d;
            mag_q      <= mag_d;
            neg_q      <= neg_d;
            bcd_q      <= bcd_d;
            negative_q <= negative_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scratch_d  = scratch_q;
        mag_d      = mag_q;
        neg_d      = neg_q;
        bcd_d      = bcd_q;
        negative_d = negative_q;
        done_d     = 1'b0;

        // Pre-correct every digit so the following doubling carries in decimal.
        adj = scratch_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
        end
        shifted = {adj[BW-2:0], mag_q[WIDTH-1]};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    neg_d     = bus.signed_mode & bus.value[WIDTH-1];
                    // Most-negative input negates to itself, which reads correctly as unsigned.
                    mag_d     = neg_d ? (~bus.value + WIDTH'(1)) : bus.value;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                mag_d     = mag_q << 1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    bcd_d      = shifted;
                    negative_d = neg_q;
                    done_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.negative = negative_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed table, random vs. arithmetic model, handshake and reset sequences.
module tb_bin_to_bcd_seq;
    logic CLOCK_50 = 1'b0;
    logic rst_n;

    always #10 CLOCK_50 = ~CLOCK_50;

    bin_to_bcd_seq_if #(.WIDTH(10), .DIGITS(4)) bus();

    bin_to_bcd_seq #(.WIDTH(10), .DIGITS(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sm;
        logic [9:0]  v;
        logic [15:0] bcd;
        logic        neg;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Reference: sign/magnitude by integer arithmetic, digits by divide/modulo.
    function automatic logic [16:0] model(input logic sm, input logic [9:0] v);
        int          m;
        logic        n;
        logic [15:0] b;
        n = sm & v[9];
        m = n ? (1024 - int'(v)) : int'(v);
        b = '0;
        for (int i = 0; i < 4; i++)
            b[4*i +: 4] = 4'((m / (10 ** i)) % 10);
        return {n, b};
    endfunction

    // Issues one start, scrambles the operands after sampling, waits for done.
    task automatic convert(input logic sm, input logic [9:0] v, output int lat, output int busy_cyc);
        bus.start       = 1'b1;
        bus.signed_mode = sm;
        bus.value       = v;
        tick();
        bus.start       = 1'b0;
        bus.value       = 10'($urandom);
        bus.signed_mode = 1'($urandom);
        lat      = 0;
        busy_cyc = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cyc++;
            tick();
            lat++;
        end
        if (!bus.done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int          lat, bc, k, seen;
        logic [16:0] exp;
        logic        rsm;
        logic [9:0]  rv;

        vecs[0] = '{1'b0, 10'h3FF, 16'h1023, 1'b0};
        vecs[1] = '{1'b1, 10'h200, 16'h0512, 1'b1};
        vecs[2] = '{1'b1, 10'h3FF, 16'h0001, 1'b1};
        vecs[3] = '{1'b1, 10'h1FF, 16'h0511, 1'b0};
        vecs[4] = '{1'b0, 10'h000, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 10'h000, 16'h0000, 1'b0};
        vecs[6] = '{1'b0, 10'h200, 16'h0512, 1'b0};
        vecs[7] = '{1'b0, 10'd123, 16'h0123, 1'b0};
        vecs[8] = '{1'b1, 10'h3F6, 16'h0010, 1'b1};

        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.value       = '0;
        rst_n           = 1'b1;
        #5 rst_n = 1'b0;
        tick();
        tick();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_bcd", 32'(bus.bcd), 32'h0);
        check("reset_neg", 32'(bus.negative), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("idle_bcd", 32'(bus.bcd), 32'h0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);

        for (int i = 0; i < 9; i++) begin
            convert(vecs[i].sm, vecs[i].v, lat, bc);
            check($sformatf("vec%0d_bcd", i), 32'(bus.bcd), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_neg", i), 32'(bus.negative), 32'(vecs[i].neg));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd10);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd10);
            check($sformatf("vec%0d_done_busy", i), 32'(bus.busy), 32'd0);
            tick();
            check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
            check($sformatf("vec%0d_bcd_held", i), 32'(bus.bcd), 32'(vecs[i].bcd));
        end

        for (int i = 0; i < 40; i++) begin
            rsm = 1'($urandom);
            rv  = 10'($urandom);
            exp = model(rsm, rv);
            convert(rsm, rv, lat, bc);
            check($sformatf("rand%0d_bcd v=%0h sm=%0d", i, rv, rsm), 32'(bus.bcd), 32'(exp[15:0]));
            check($sformatf("rand%0d_neg", i), 32'(bus.negative), 32'(exp[16]));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'd10);
        end

        // start during busy must be ignored; start in the done cycle must be accepted.
        tick();
        bus.start       = 1'b1;
        bus.signed_mode = 1'b0;
        bus.value       = 10'd123;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.value = 10'd999;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < 40) begin
            tick();
            k++;
        end
        check("hs_first_done", 32'(bus.done), 32'd1);
        check("hs_first_bcd", 32'(bus.bcd), 32'h0123);
        bus.start = 1'b1;
        bus.value = 10'd45;
        tick();
        bus.start = 1'b0;
        k = 1;
        while (!bus.done && k < 40) begin
            tick();
            k++;
        end
        check("hs_back_to_back_gap", 32'(k), 32'd11);
        check("hs_second_bcd", 32'(bus.bcd), 32'h0045);

        // Abort a conversion with reset three cycles after start.
        tick();
        bus.start = 1'b1;
        bus.value = 10'd300;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_bcd", 32'(bus.bcd), 32'h0);
        check("abort_neg", 32'(bus.negative), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_bcd_stays", 32'(bus.bcd), 32'h0);
        convert(1'b0, 10'd7, lat, bc);
        check("restart_bcd", 32'(bus.bcd), 32'h0007);
        check("restart_latency", 32'(lat), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
